fast_square_sweep_ctrl: RTL and testbench

Sweep sequencer that drives the control strobes of the fast-square receive stage: it pulses the receiver's reset so the receiver re-latches its frequency settings, opens fixed-length record windows, and issues one frequency-step pulse after each window. It sits directly upstream of the receiver. It decodes its own settings from the same serial settings bus, and its outputs connect 1:1 to the receiver's `reset`, `record` and `freq_step` inputs.

---
 rtl/fast_square_sweep_ctrl_if.sv | 28 ++
 rtl/fast_square_sweep_ctrl.sv | 158 +++++++++++++++
 tb/tb_fast_square_sweep_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fast_square_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fast_square_sweep_ctrl_if
// Brief    : Settings bus in, receiver strobes and sweep status out.
// Revision : 1.0 - initial release
// ============================================================================
interface fast_square_sweep_ctrl_if;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic        rx_reset;
    logic        record;
    logic        freq_step;
    logic        busy;
    logic        done;
    logic [15:0] step_index;

    modport master (
        output serial_addr, serial_data, serial_strobe,
        input  rx_reset, record, freq_step, busy, done, step_index
    );

    modport slave (
        input  serial_addr, serial_data, serial_strobe,
        output rx_reset, record, freq_step, busy, done, step_index
    );
endinterface
`default_nettype wire

// File: rtl/fast_square_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fast_square_sweep_ctrl
// Brief    : Sweep sequencer: receiver reset pulse, record windows, freq steps.
// Revision : 1.0 - initial release
// ============================================================================
module fast_square_sweep_ctrl #(
    parameter int         RECORD_TICKS_LOG2 = 14,
    parameter logic [6:0] STEPSADDR         = 7'd3,
    parameter logic [6:0] GAPADDR           = 7'd4,
    parameter logic [6:0] CTRLADDR          = 7'd5
) (
    input  logic                    clock,
    input  logic                    reset,
    fast_square_sweep_ctrl_if.slave ctrl_bus
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_gap  = 3'd2;
    localparam logic [2:0] c_st_rec  = 3'd3;
    localparam logic [2:0] c_st_step = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    localparam logic [RECORD_TICKS_LOG2-1:0] c_win_last = '1;
    localparam logic [RECORD_TICKS_LOG2-1:0] c_win_one  =
        {{(RECORD_TICKS_LOG2-1){1'b0}}, 1'b1};

    // Reset asserts immediately but releases two clock edges later.
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    logic        w_wr_steps;
    logic        w_wr_gap;
    logic        w_wr_ctrl;
    logic        w_arm;
    logic        w_abort;
    logic        w_unused_data;

    assign w_wr_steps    = ctrl_bus.serial_strobe && (ctrl_bus.serial_addr == STEPSADDR);
    assign w_wr_gap      = ctrl_bus.serial_strobe && (ctrl_bus.serial_addr == GAPADDR);
    assign w_wr_ctrl     = ctrl_bus.serial_strobe && (ctrl_bus.serial_addr == CTRLADDR);
    assign w_arm         = w_wr_ctrl && ctrl_bus.serial_data[0];
    assign w_abort       = w_wr_ctrl && ctrl_bus.serial_data[1];
    assign w_unused_data = ^ctrl_bus.serial_data[31:16];

    logic [15:0] r_steps;
    logic [15:0] r_gap;
    logic        r_cont;

    always_ff @(posedge clock or posedge w_rst) begin
        if (w_rst) begin
            r_steps <= 16'd0;
            r_gap   <= 16'd0;
            r_cont  <= 1'b0;
        end else begin
            if (w_wr_steps) r_steps <= ctrl_bus.serial_data[15:0];
            if (w_wr_gap)   r_gap   <= ctrl_bus.serial_data[15:0];
            if (w_wr_ctrl)  r_cont  <= ctrl_bus.serial_data[2];
        end
    end

    logic [2:0]                   r_state;
    logic [2:0]                   w_next;
    logic                         w_load;
    logic [15:0]                  r_n_lat;
    logic [15:0]                  r_g_lat;
    logic [15:0]                  r_gap_cnt;
    logic [RECORD_TICKS_LOG2-1:0] r_win_cnt;
    logic [15:0]                  r_step_index;
    logic                         r_rx_reset;
    logic                         r_record;
    logic                         r_freq_step;
    logic                         r_busy;
    logic                         r_done;

    // w_load marks an arm (manual or continuous) that snapshots the settings.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_arm) begin
                    w_next = c_st_load;
                    w_load = 1'b1;
                end
            end
            c_st_load: w_next = (r_n_lat == 16'd0) ? c_st_done : c_st_gap;
            c_st_gap:  if (r_gap_cnt == r_g_lat) w_next = c_st_rec;
            c_st_rec:  if (r_win_cnt == c_win_last) w_next = c_st_step;
            c_st_step: w_next = (r_step_index == r_n_lat) ? c_st_done : c_st_gap;
            c_st_done: begin
                if (w_arm || r_cont) begin
                    w_next = c_st_load;
                    w_load = 1'b1;
                end
            end
            default:   w_next = c_st_idle;
        endcase
        if (w_abort) begin
            w_next = c_st_idle;
            w_load = 1'b0;
        end
    end

    // Strobes are decoded from the next state so they are registered outputs.
    always_ff @(posedge clock or posedge w_rst) begin
        if (w_rst) begin
            r_state      <= c_st_idle;
            r_n_lat      <= 16'd0;
            r_g_lat      <= 16'd0;
            r_gap_cnt    <= 16'd0;
            r_win_cnt    <= '0;
            r_step_index <= 16'd0;
            r_rx_reset   <= 1'b0;
            r_record     <= 1'b0;
            r_freq_step  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_gap_cnt <= (r_state == c_st_gap) ? r_gap_cnt + 16'd1 : 16'd0;
            r_win_cnt <= (r_state == c_st_rec) ? r_win_cnt + c_win_one : '0;
            if (w_load) begin
                r_n_lat      <= r_steps;
                r_g_lat      <= r_gap;
                r_step_index <= 16'd0;
                r_done       <= 1'b0;
            end else begin
                if (w_next == c_st_step) r_step_index <= r_step_index + 16'd1;
                if (w_next == c_st_done) r_done <= 1'b1;
            end
            r_rx_reset  <= (w_next == c_st_load);
            r_record    <= (w_next == c_st_rec);
            r_freq_step <= (w_next == c_st_step);
            r_busy      <= (w_next != c_st_idle) && (w_next != c_st_done);
        end
    end

    assign ctrl_bus.rx_reset   = r_rx_reset;
    assign ctrl_bus.record     = r_record;
    assign ctrl_bus.freq_step  = r_freq_step;
    assign ctrl_bus.busy       = r_busy;
    assign ctrl_bus.done       = r_done;
    assign ctrl_bus.step_index = r_step_index;

endmodule
`default_nettype wire

// File: tb/tb_fast_square_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fast_square_sweep_ctrl
// Brief    : Directed bench for the sweep sequencer with a 16-cycle window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fast_square_sweep_ctrl;

    localparam int         c_log2  = 4;
    localparam int         c_win   = 16;
    localparam logic [6:0] c_a_stp = 7'd3;
    localparam logic [6:0] c_a_gap = 7'd4;
    localparam logic [6:0] c_a_ctl = 7'd5;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fast_square_sweep_ctrl_if bus ();

    fast_square_sweep_ctrl #(
        .RECORD_TICKS_LOG2 (c_log2),
        .STEPSADDR         (c_a_stp),
        .GAPADDR           (c_a_gap),
        .CTRLADDR          (c_a_ctl)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .ctrl_bus (bus)
    );

    always #5 clock = ~clock;

    int          n_cmp    = 0;
    int          n_fail   = 0;
    int          sw_cyc   = 0;
    int          inj_at   = -1;
    logic [6:0]  inj_addr = 7'd0;
    logic [31:0] inj_data = 32'd0;

    // {rx_reset, record, freq_step, busy}
    function automatic logic [3:0] strobes();
        return {bus.rx_reset, bus.record, bus.freq_step, bus.busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [6:0] addr, input logic [31:0] data);
        bus.serial_addr   = addr;
        bus.serial_data   = data;
        bus.serial_strobe = 1'b1;
        tick();
        bus.serial_strobe = 1'b0;
    endtask

    // One clock that optionally carries a settings write mid-sweep.
    task automatic step_clk();
        if (sw_cyc == inj_at) begin
            bus.serial_addr   = inj_addr;
            bus.serial_data   = inj_data;
            bus.serial_strobe = 1'b1;
        end
        tick();
        bus.serial_strobe = 1'b0;
        sw_cyc++;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, {28'd0, strobes()}, 32'h0);
        end
    endtask

    // Entered in the LOAD cycle; leaves in the first DONE cycle.
    task automatic check_sweep(input int n, input int g, input string tag);
        sw_cyc = 0;
        chk({tag, " load"}, {28'd0, strobes()}, 32'h9);
        chk({tag, " load idx"}, {16'd0, bus.step_index}, 32'd0);
        chk({tag, " load done"}, {31'd0, bus.done}, 32'd0);
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c <= g; c++) begin
                step_clk();
                chk({tag, " gap"}, {28'd0, strobes()}, 32'h1);
            end
            for (int c = 0; c < c_win; c++) begin
                step_clk();
                chk({tag, " rec"}, {28'd0, strobes()}, 32'h5);
            end
            step_clk();
            chk({tag, " step"}, {28'd0, strobes()}, 32'h3);
            chk({tag, " step idx"}, {16'd0, bus.step_index}, s + 1);
        end
        step_clk();
        chk({tag, " done strobes"}, {28'd0, strobes()}, 32'h0);
        chk({tag, " done flag"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " done idx"}, {16'd0, bus.step_index}, n);
        inj_at = -1;
    endtask

    initial begin
        bus.serial_addr   = 7'd0;
        bus.serial_data   = 32'd0;
        bus.serial_strobe = 1'b0;
        repeat (3) tick();
        chk("reset strobes", {28'd0, strobes()}, 32'h0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset idx", {16'd0, bus.step_index}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        chk("release idle", {28'd0, strobes()}, 32'h0);

        // Basic sweep, with an arm written while busy that must be ignored.
        wr(c_a_stp, 32'd3);
        wr(c_a_gap, 32'd2);
        inj_at   = 10;
        inj_addr = c_a_ctl;
        inj_data = 32'd1;
        wr(c_a_ctl, 32'd1);
        check_sweep(3, 2, "basic");
        idle_cycles(3, "basic hold");
        chk("basic hold done", {31'd0, bus.done}, 32'd1);

        wr(c_a_stp, 32'd0);
        wr(c_a_ctl, 32'd1);
        check_sweep(0, 2, "zero");
        idle_cycles(4, "zero hold");

        // Abort in the fifth cycle of the second window.
        wr(c_a_stp, 32'd3);
        wr(c_a_gap, 32'd2);
        wr(c_a_ctl, 32'd1);
        repeat (28) tick();
        chk("abort pre rec", {28'd0, strobes()}, 32'h5);
        chk("abort pre idx", {16'd0, bus.step_index}, 32'd1);
        wr(c_a_ctl, 32'd2);
        chk("abort strobes", {28'd0, strobes()}, 32'h0);
        chk("abort idx", {16'd0, bus.step_index}, 32'd1);
        chk("abort done", {31'd0, bus.done}, 32'd0);
        idle_cycles(25, "abort idle");
        wr(c_a_ctl, 32'd1);
        check_sweep(3, 2, "rearm");

        // Continuous: STEPS changed to 1 during the first sweep.
        wr(c_a_stp, 32'd2);
        wr(c_a_gap, 32'd1);
        inj_at   = 5;
        inj_addr = c_a_stp;
        inj_data = 32'd1;
        wr(c_a_ctl, 32'd5);
        check_sweep(2, 1, "cont1");
        tick();
        check_sweep(1, 1, "cont2");
        wr(c_a_ctl, 32'd2);
        chk("cont stop", {28'd0, strobes()}, 32'h0);
        idle_cycles(5, "cont idle");

        wr(c_a_ctl, 32'd3);
        chk("ctrl3 now", {28'd0, strobes()}, 32'h0);
        idle_cycles(5, "ctrl3 idle");

        // Async reset in the second window of a 2-step, zero-gap sweep.
        wr(c_a_stp, 32'd2);
        wr(c_a_gap, 32'd0);
        wr(c_a_ctl, 32'd5);
        repeat (22) tick();
        chk("arst pre rec", {28'd0, strobes()}, 32'h5);
        chk("arst pre idx", {16'd0, bus.step_index}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst strobes", {28'd0, strobes()}, 32'h0);
        chk("arst idx", {16'd0, bus.step_index}, 32'd0);
        chk("arst done", {31'd0, bus.done}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("arst released", {28'd0, strobes()}, 32'h0);
        wr(c_a_ctl, 32'd1);
        check_sweep(0, 0, "post rst steps");
        wr(c_a_stp, 32'd1);
        wr(c_a_ctl, 32'd1);
        check_sweep(1, 0, "post rst gap");
        idle_cycles(3, "post rst hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
